// File: rtl/riscv_pkg.sv
// Core-wide pipeline payload types and sizing shared between front-end stages.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned FQ_DEPTH = 8;

    // One fetch-queue slot: instruction word plus its PC
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage : riscv_pkg

// File: rtl/fetch_queue.sv
// Dual-issue in-order instruction queue between fetch and decode: up to two
// pushes and two pops per cycle, oldest two entries presented as lanes A/B.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned DEPTH      = FQ_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   InstrA_i,
    input  logic [DATA_WIDTH-1:0]   InstrB_i,
    input  logic [DATA_WIDTH-1:0]   PCA_i,
    input  logic [DATA_WIDTH-1:0]   PCB_i,
    input  logic [1:0]              FetchValid_i,
    output logic                    FetchReady_o,
    output logic [DATA_WIDTH-1:0]   InstrA_o,
    output logic [DATA_WIDTH-1:0]   InstrB_o,
    output logic [DATA_WIDTH-1:0]   PCA_o,
    output logic [DATA_WIDTH-1:0]   PCB_o,
    output logic [1:0]              IssueValid_o,
    input  logic [1:0]              IssueTake_i,
    input  logic                    Flush_i,
    output logic [$clog2(DEPTH):0]  Count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_ready;
    logic               w_valid_a;
    logic               w_valid_b;
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic [PTR_W-1:0]   w_head_p1;
    logic [PTR_W-1:0]   w_tail_p1;

    // Ready looks only at the registered count; same-cycle pops earn no credit
    always_comb begin
        w_ready   = (CNT_W'(DEPTH) - r_count) >= CNT_W'(2);
        w_valid_a = r_count != '0;
        w_valid_b = r_count >= CNT_W'(2);
        w_head_p1 = r_head + PTR_W'(1);
        w_tail_p1 = r_tail + PTR_W'(1);

        w_push = 2'd0;
        if (w_ready && FetchValid_i[0]) begin
            w_push = FetchValid_i[1] ? 2'd2 : 2'd1;
        end

        w_pop = 2'(IssueTake_i[0] & w_valid_a)
              + 2'(IssueTake_i[1] & IssueTake_i[0] & w_valid_b);
    end

    // Pointer and occupancy state; flush overrides both push and pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (Flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push);
            r_count <= r_count - CNT_W'(w_pop) + CNT_W'(w_push);
        end
    end

    // Storage is deliberately unreset; validity is tracked by the count alone
    always_ff @(posedge clk_i) begin
        if (!Flush_i && (w_push != 2'd0)) begin
            r_mem[r_tail].instr <= XLEN'(InstrA_i);
            r_mem[r_tail].pc    <= XLEN'(PCA_i);
        end
        if (!Flush_i && (w_push == 2'd2)) begin
            r_mem[w_tail_p1].instr <= XLEN'(InstrB_i);
            r_mem[w_tail_p1].pc    <= XLEN'(PCB_i);
        end
    end

    always_comb begin
        FetchReady_o = w_ready;
        IssueValid_o = {w_valid_b, w_valid_a};
        Count_o      = r_count;
        InstrA_o     = '0;
        PCA_o        = '0;
        InstrB_o     = '0;
        PCB_o        = '0;
        if (w_valid_a) begin
            InstrA_o = DATA_WIDTH'(r_mem[r_head].instr);
            PCA_o    = DATA_WIDTH'(r_mem[r_head].pc);
        end
        if (w_valid_b) begin
            InstrB_o = DATA_WIDTH'(r_mem[w_head_p1].instr);
            PCB_o    = DATA_WIDTH'(r_mem[w_head_p1].pc);
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table with explicit expectations,
// backed by a reference queue scoreboard and hand-written corner sequences.
module tb_fetch_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [DW-1:0] InstrA_i, InstrB_i, PCA_i, PCB_i;
    logic [1:0]    FetchValid_i;
    logic          FetchReady_o;
    logic [DW-1:0] InstrA_o, InstrB_o, PCA_o, PCB_o;
    logic [1:0]    IssueValid_o;
    logic [1:0]    IssueTake_i;
    logic          Flush_i;
    logic [3:0]    Count_o;

    fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .InstrA_i     (InstrA_i),
        .InstrB_i     (InstrB_i),
        .PCA_i        (PCA_i),
        .PCB_i        (PCB_i),
        .FetchValid_i (FetchValid_i),
        .FetchReady_o (FetchReady_o),
        .InstrA_o     (InstrA_o),
        .InstrB_o     (InstrB_o),
        .PCA_o        (PCA_o),
        .PCB_o        (PCB_o),
        .IssueValid_o (IssueValid_o),
        .IssueTake_i  (IssueTake_i),
        .Flush_i      (Flush_i),
        .Count_o      (Count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;

    typedef struct {
        logic [1:0]    fv;
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        logic [1:0]    take;
        logic          flush;
        int            exp_cnt;
        logic [1:0]    exp_valid;
        logic          exp_ready;
        logic [DW-1:0] exp_pca;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Instruction word derived from PC so every entry is distinguishable
    function automatic logic [DW-1:0] ins(input logic [DW-1:0] pc);
        return 32'h0050_0093 ^ {pc[23:0], 8'h00};
    endfunction

    function automatic vec_t mk(input logic [1:0] fv, input logic [DW-1:0] pa,
                                input logic [DW-1:0] pb, input logic [1:0] take,
                                input logic flush, input int cnt,
                                input logic [1:0] v, input logic rdy,
                                input logic [DW-1:0] pca);
        vec_t r;
        r.fv = fv; r.pa = pa; r.pb = pb; r.take = take; r.flush = flush;
        r.exp_cnt = cnt; r.exp_valid = v; r.exp_ready = rdy; r.exp_pca = pca;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the reference queue contents
    task automatic check_state(input string tag);
        int sz;
        sz = sb.size();
        chk({tag, "_count"}, DW'(Count_o), DW'(sz));
        chk({tag, "_valid"}, DW'(IssueValid_o), DW'({sz >= 2, sz >= 1}));
        chk({tag, "_ready"}, DW'(FetchReady_o), DW'((DEPTH - sz) >= 2));
        chk({tag, "_pca"},   PCA_o,    (sz >= 1) ? sb[0].pc    : '0);
        chk({tag, "_insa"},  InstrA_o, (sz >= 1) ? sb[0].instr : '0);
        chk({tag, "_pcb"},   PCB_o,    (sz >= 2) ? sb[1].pc    : '0);
        chk({tag, "_insb"},  InstrB_o, (sz >= 2) ? sb[1].instr : '0);
    endtask

    task automatic idle_inputs();
        FetchValid_i = 2'b00; IssueTake_i = 2'b00; Flush_i = 1'b0;
        InstrA_i = '0; InstrB_i = '0; PCA_i = '0; PCB_i = '0;
    endtask

    // One clock: drive, score popped lanes, update model, check after the edge
    task automatic cycle(input logic [1:0] fv, input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                         input logic [1:0] take, input logic flush);
        ent_t e;
        int   npop;
        bit   rdy;
        FetchValid_i = fv; PCA_i = pa; InstrA_i = ins(pa);
        PCB_i = pb; InstrB_i = ins(pb);
        IssueTake_i = take; Flush_i = flush;
        #1;
        rdy  = (DEPTH - sb.size()) >= 2;
        npop = 0;
        if (take[0] && sb.size() >= 1) npop = 1;
        if (take == 2'b11 && sb.size() >= 2) npop = 2;
        if (flush) begin
            sb.delete();
        end else begin
            for (int i = 0; i < npop; i++) begin
                e = sb.pop_front();
                chk("pop_pc",  (i == 0) ? PCA_o : PCB_o, e.pc);
                chk("pop_ins", (i == 0) ? InstrA_o : InstrB_o, e.instr);
            end
            if (rdy && fv[0]) begin
                e.pc = pa; e.instr = ins(pa); sb.push_back(e);
                if (fv[1]) begin
                    e.pc = pb; e.instr = ins(pb); sb.push_back(e);
                end
            end
        end
        @(posedge clk_i);
        #1;
        check_state("cyc");
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pc;
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        check_state("rst");
        #6 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Vector table: inputs plus explicitly derived expectations
        tbl.push_back(mk(2'b01, 32'h00, 32'h00, 2'b00, 0, 1, 2'b01, 1, 32'h00));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b01, 0, 0, 2'b00, 1, 32'h00));
        tbl.push_back(mk(2'b11, 32'h00, 32'h04, 2'b00, 0, 2, 2'b11, 1, 32'h00));
        tbl.push_back(mk(2'b11, 32'h08, 32'h0C, 2'b00, 0, 4, 2'b11, 1, 32'h00));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b11, 0, 2, 2'b11, 1, 32'h08));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b11, 0, 0, 2'b00, 1, 32'h00));
        tbl.push_back(mk(2'b11, 32'h10, 32'h14, 2'b00, 0, 2, 2'b11, 1, 32'h10));
        tbl.push_back(mk(2'b11, 32'h18, 32'h1C, 2'b00, 0, 4, 2'b11, 1, 32'h10));
        tbl.push_back(mk(2'b11, 32'h20, 32'h24, 2'b00, 0, 6, 2'b11, 1, 32'h10));
        tbl.push_back(mk(2'b01, 32'h28, 32'h00, 2'b00, 0, 7, 2'b11, 0, 32'h10));
        tbl.push_back(mk(2'b11, 32'h90, 32'h94, 2'b00, 0, 7, 2'b11, 0, 32'h10));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b01, 0, 6, 2'b11, 1, 32'h14));
        tbl.push_back(mk(2'b11, 32'h2C, 32'h30, 2'b00, 0, 8, 2'b11, 0, 32'h14));
        tbl.push_back(mk(2'b11, 32'hA0, 32'hA4, 2'b00, 0, 8, 2'b11, 0, 32'h14));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b10, 0, 8, 2'b11, 0, 32'h14));
        tbl.push_back(mk(2'b11, 32'hB0, 32'hB4, 2'b11, 0, 6, 2'b11, 1, 32'h1C));
        tbl.push_back(mk(2'b11, 32'h34, 32'h38, 2'b11, 0, 6, 2'b11, 1, 32'h24));
        tbl.push_back(mk(2'b00, 32'h00, 32'h00, 2'b01, 0, 5, 2'b11, 1, 32'h28));
        tbl.push_back(mk(2'b11, 32'hC0, 32'hC4, 2'b11, 1, 0, 2'b00, 1, 32'h00));

        foreach (tbl[i]) begin
            cycle(tbl[i].fv, tbl[i].pa, tbl[i].pb, tbl[i].take, tbl[i].flush);
            chk("tbl_count", DW'(Count_o), DW'(tbl[i].exp_cnt));
            chk("tbl_valid", DW'(IssueValid_o), DW'(tbl[i].exp_valid));
            chk("tbl_ready", DW'(FetchReady_o), DW'(tbl[i].exp_ready));
            chk("tbl_pca",   PCA_o, tbl[i].exp_pca);
        end

        // Steady-state push 2 / pop 2 with pointer wrap; PCs must stay contiguous
        pc = 32'h1000;
        cycle(2'b11, pc, pc + 4, 2'b00, 0);
        pc = pc + 8;
        for (int i = 0; i < 20; i++) begin
            chk("wrap_pca", PCA_o, pc - 8);
            cycle(2'b11, pc, pc + 4, 2'b11, 0);
            chk("wrap_count", DW'(Count_o), 32'd2);
            pc = pc + 8;
        end
        cycle(2'b00, 0, 0, 2'b11, 0);

        // Count = 1: take 11 pops only lane A
        cycle(2'b01, 32'h2000, 0, 2'b00, 0);
        cycle(2'b00, 0, 0, 2'b11, 0);
        chk("one_take11_count", DW'(Count_o), 32'd0);

        // Asynchronous reset mid-stream, no clock edge
        cycle(2'b11, 32'h3000, 32'h3004, 2'b00, 0);
        cycle(2'b01, 32'h3008, 0, 2'b00, 0);
        chk("pre_rst_count", DW'(Count_o), 32'd3);
        rst_ni = 1'b0;
        #1;
        sb.delete();
        check_state("async_rst");
        #2 rst_ni = 1'b1;

        // Take 10 on count 2 pops nothing
        cycle(2'b11, 32'h4000, 32'h4004, 2'b00, 0);
        cycle(2'b00, 0, 0, 2'b10, 0);
        chk("take10_count", DW'(Count_o), 32'd2);
        chk("take10_pca", PCA_o, 32'h4000);

        // Empty queue ignores take; then short random traffic against the model
        cycle(2'b00, 0, 0, 2'b11, 0);
        cycle(2'b00, 0, 0, 2'b11, 0);
        pc = 32'h5000;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] fv;
            logic [1:0] tk;
            fv = 2'($urandom_range(0, 3));
            tk = 2'($urandom_range(0, 3));
            cycle(fv, pc, pc + 4, tk, ($urandom_range(0, 19) == 0));
            pc = pc + 8;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction queue between fetch and decode. Accepts up to two in-order instructions per cycle from fetch and holds them in a circular buffer. Presents the oldest two entries as lanes A and B to the decode stage, which feeds the per-lane immediate extender. Decouples fetch stalls from decode stalls and supports a full flush on redirect.

## Interface
- DATA_WIDTH, 32, instruction and PC width
- DEPTH, 8, entries; power of two, ≥4
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous, active-low reset
- InstrA_i  input  DATA_WIDTH  older fetched instruction
- InstrB_i  input  DATA_WIDTH  younger fetched instruction
- PCA_i  input  DATA_WIDTH  PC of InstrA_i
- PCB_i  input  DATA_WIDTH  PC of InstrB_i
- FetchValid_i  input  2  bit0 = lane A valid, bit1 = lane B valid; bit1 ignored unless bit0 set
- FetchReady_o  output  2'→1  1  queue can accept two entries this cycle
- InstrA_o / InstrB_o  output  DATA_WIDTH  head / head+1 instruction, 0 when lane invalid
- PCA_o / PCB_o  output  DATA_WIDTH  head / head+1 PC, 0 when lane invalid
- IssueValid_o  output  2  bit0 = ≥1 entry, bit1 = ≥2 entries
- IssueTake_i  input  2  decode consumes: 00 none, 01 lane A, 11 both; 10 treated as 00
- Flush_i  input  1  discard all contents
- Count_o  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {instr, pc}; head pointer (rd), tail pointer (wr), occupancy counter, pointers $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- FetchReady_o = (DEPTH − Count_o) ≥ 2, from current registered count only (no credit for same-cycle pops).
- Push count: 0 if !FetchReady_o or !FetchValid_i[0]; 1 if FetchValid_i = 01; 2 if 11. Lane A written at tail, lane B at tail+1; tail advances by push count.
- Pop count: IssueTake_i[0]&IssueValid_o[0] + (IssueTake_i[1]&IssueTake_i[0]&IssueValid_o[1]). Take bits beyond valid lanes are masked, never underflow.
- Count_next = Count − pop + push; overflow impossible by ready rule.
- Outputs: lane A reads entry[head], lane B reads entry[head+1] (wraps); data gated to 0 when corresponding IssueValid_o bit low.
- Flush_i: head, tail, count cleared to 0 next edge; overrides push and pop in the same cycle (incoming fetch data dropped).
- Order strictly preserved: lane A always older than lane B, entries issue in push order.
- No fetch-to-issue bypass: entry pushed at edge N visible at outputs after edge N.

## Timing
- Reset (rst_ni low, asynchronous): head = tail = 0, Count_o = 0, IssueValid_o = 00, all data outputs 0, FetchReady_o = 1. Storage array not reset.
- Reset mid-operation: contents lost immediately, outputs reach reset values without a clock edge.
- Fetch-to-issue latency: 1 cycle (push at edge N, IssueValid_o set after N).
- Simultaneous push and pop: both applied same edge; at Count = DEPTH−2 with pop 2 and push 2, Count stays DEPTH−2.
- Full (Count ≥ DEPTH−1): FetchReady_o = 0, fetch must hold; pops still allowed.
- Empty: IssueValid_o = 00, IssueTake_i ignored.
- Count = 1: only lane A valid; IssueTake_i = 11 pops one.
- All outputs combinational from registered state; no input-to-output combinational path.

## Structure
- Shared package fetch_queue_pkg-free: entry typedef fq_entry_t {instr, pc} and DEPTH default go in the core-wide riscv_pkg alongside other pipeline payload types.
- Single module; no sub-module. Storage as an unreset register array, pointer and count logic inline.

## Test plan
- Reset then single push FetchValid_i=01, InstrA_i=0x00500093, PCA_i=0x0: next cycle IssueValid_o=01, InstrA_o=0x00500093, Count_o=1, InstrB_o=0.
- Push pairs (PC 0x0/0x4, 0x8/0xC) with IssueTake_i=00: Count_o=4; then IssueTake_i=11 twice: lanes show 0x0/0x4 then 0x8/0xC, Count_o=0.
- Fill to DEPTH−1 (7) and DEPTH: FetchReady_o=0 at Count ≥7, further FetchValid_i=11 ignored, Count unchanged.
- Wrap-around: 20 cycles of push 2/pop 2 at steady Count=2: PCs issue contiguous (step 4), no loss, pointers wrap past 7.
- Flush_i=1 with Count=5, FetchValid_i=11, IssueTake_i=11 same cycle: next cycle Count_o=0, IssueValid_o=00, FetchReady_o=1.
- Assert rst_ni low mid-stream with Count=3, no clock edge: IssueValid_o=00, Count_o=0 immediately; IssueTake_i=10 on Count=2 pops nothing.
